i_image_writer: RTL and testbench

Stream-to-memory writer for the image pipeline. Accepts one pixel per valid/ready handshake from the processing stage. Writes each pixel as one 32-bit word to SRAM at a linearly advancing address, tracking the column and row position. Signals completion when a frame of `img_width × img_height` pixels has been committed. It is the write-side counterpart of the image read path's row/column indexing: the read path scans the source image out, this block scans the result image back in.

---
 rtl/i_image_pkg.sv | 19 +
 rtl/i_write_addr_gen.sv | 84 ++++++++
 rtl/i_image_writer.sv | 122 ++++++++++++
 tb/tb_i_image_writer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/i_image_pkg.sv
// Shared types and constants for the image writer.
//   writer_state_t : writer FSM state encoding
//   DIM_W          : default width of image dimension and index fields
//   PIX_BYTES      : bytes occupied by one pixel word in memory
//   PIX_W          : width of an RGB pixel
package i_image_pkg;

  localparam int unsigned DIM_W     = 13;
  localparam int unsigned PIX_BYTES = 4;
  localparam int unsigned PIX_W     = 24;

  typedef enum logic [1:0] {
    StIdle,
    StAccept,
    StWrite,
    StDone
  } writer_state_t;

endpackage

// File: rtl/i_write_addr_gen.sv
// Column/row counters and byte-address accumulator for the image writer.
// Ports:
//   clk, clear       : clock and synchronous active-high reset
//   load             : latch base_addr/width/height, zero col/row
//   advance          : step to the next pixel position
//   base_addr        : byte address of pixel (0,0)
//   width, height    : frame dimensions
//   col, row, addr   : current pixel position and its byte address
//   last             : current position is the final pixel of the frame
module i_write_addr_gen #(
  parameter int unsigned DIM_W  = 13,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  output logic [DIM_W-1:0]  col,
  output logic [DIM_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  import i_image_pkg::*;

  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              col_last;
  logic              row_last;

  assign col_last = (col_q == width_q - DIM_W'(1));
  assign row_last = (row_q == height_q - DIM_W'(1));
  assign last     = col_last && row_last;

  always_comb begin
    width_d  = width_q;
    height_d = height_q;
    col_d    = col_q;
    row_d    = row_q;
    addr_d   = addr_q;
    if (load) begin
      width_d  = width;
      height_d = height;
      col_d    = '0;
      row_d    = '0;
      addr_d   = base_addr;
    end else if (advance) begin
      // Address wraps modulo 2^ADDR_W; span overflow is not checked.
      addr_d = addr_q + ADDR_W'(PIX_BYTES);
      if (col_last) begin
        col_d = '0;
        row_d = row_q + DIM_W'(1);
      end else begin
        col_d = col_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      width_q  <= '0;
      height_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
    end else begin
      width_q  <= width_d;
      height_q <= height_d;
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign addr = addr_q;

endmodule

// File: rtl/i_image_writer.sv
// Stream-to-memory writer: accepts one RGB pixel per valid/ready handshake and
// writes it as a 32-bit word at a linearly advancing SRAM byte address,
// pulsing frame_done once img_width x img_height pixels are committed.
// Ports:
//   clk, clear                    : clock and synchronous active-high reset
//   start                         : begin a frame (sampled only when idle)
//   base_addr, img_width, img_height : frame parameters, latched on start
//   pix_valid, pix_data, pix_ready   : upstream pixel handshake
//   mem_write, mem_addr, mem_wdata, mem_wait : SRAM write port
//   col, row                      : position of the next pixel to accept
//   busy, frame_done              : status
module i_image_writer #(
  parameter int unsigned DIM_W  = 13,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  input  logic              pix_valid,
  input  logic [23:0]       pix_data,
  output logic              pix_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_wait,
  output logic [DIM_W-1:0]  col,
  output logic [DIM_W-1:0]  row,
  output logic              busy,
  output logic              frame_done
);
  import i_image_pkg::*;

  writer_state_t state_q, state_d;
  logic          load;
  logic          advance;
  logic          capture;
  logic          last;
  logic [31:0]   wdata_q, wdata_d;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Zero-sized frames are dropped so last can never be missed.
        if (start && (img_width != '0) && (img_height != '0)) begin
          load    = 1'b1;
          state_d = StAccept;
        end
      end
      StAccept: begin
        if (pix_valid) begin
          capture = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (!mem_wait) begin
          if (last) begin
            state_d = StDone;
          end else begin
            advance = 1'b1;
            state_d = StAccept;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    wdata_d = wdata_q;
    if (capture) begin
      wdata_d = {{(32 - PIX_W){1'b0}}, pix_data};
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= StIdle;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
    end
  end

  i_write_addr_gen #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .clear     (clear),
    .load      (load),
    .advance   (advance),
    .base_addr (base_addr),
    .width     (img_width),
    .height    (img_height),
    .col       (col),
    .row       (row),
    .addr      (mem_addr),
    .last      (last)
  );

  // All status outputs decode the state register only.
  assign pix_ready  = (state_q == StAccept);
  assign mem_write  = (state_q == StWrite);
  assign frame_done = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_i_image_writer.sv
module tb_i_image_writer;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] base_addr;
  logic [12:0] img_width;
  logic [12:0] img_height;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wait;
  logic [12:0] col;
  logic [12:0] row;
  logic        busy;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] base;
    logic [12:0] w;
    logic [12:0] h;
    int          stall_idx;
    int          stall_len;
    bit          restart;
    int          exp_cycles;
  } frame_t;

  frame_t vecs[5];

  i_image_writer #(
    .DIM_W  (13),
    .ADDR_W (32)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .start      (start),
    .base_addr  (base_addr),
    .img_width  (img_width),
    .img_height (img_height),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wait   (mem_wait),
    .col        (col),
    .row        (row),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame and checks every write against the scoreboard. Cycle 1 is
  // the cycle in which start is presented.
  task automatic run_frame(input frame_t f);
    int          n;
    int          k;
    int          wr;
    int          stall_left;
    int          done_c;
    logic [23:0] px;
    logic [63:0] e;
    n          = int'(f.w) * int'(f.h);
    k          = 0;
    wr         = 0;
    stall_left = f.stall_len;
    done_c     = 0;
    exp_q.delete();
    @(negedge clk);
    base_addr  = f.base;
    img_width  = f.w;
    img_height = f.h;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= 200 && done_c == 0; c++) begin
      start = f.restart && (c == 5);
      if (start) begin
        base_addr  = 32'h0000_9000;
        img_width  = 13'd1;
        img_height = 13'd1;
      end
      if (frame_done) begin
        done_c = c;
        chk("busy in done", busy, 1);
        chk("no write in done", mem_write, 0);
      end
      pix_valid = 1'b0;
      mem_wait  = 1'b0;
      if (pix_ready) begin
        chk("col", col, 64'(k % int'(f.w)));
        chk("row", row, 64'(k / int'(f.w)));
        chk("no write while ready", mem_write, 0);
        px        = 24'($urandom);
        pix_data  = px;
        pix_valid = 1'b1;
        exp_q.push_back({f.base + 32'(4 * k), 8'h00, px});
        k++;
      end
      if (mem_write) begin
        chk("ready low in write", pix_ready, 0);
        if (exp_q.size() == 0) begin
          chk("spurious write", 1, 0);
        end else begin
          e = exp_q[0];
          chk("mem_addr", mem_addr, 64'(e[63:32]));
          chk("mem_wdata", mem_wdata, 64'(e[31:0]));
          if (wr == f.stall_idx && stall_left > 0) begin
            mem_wait = 1'b1;
            stall_left--;
          end else begin
            void'(exp_q.pop_front());
            wr++;
          end
        end
      end
      @(negedge clk);
    end
    start     = 1'b0;
    pix_valid = 1'b0;
    mem_wait  = 1'b0;
    if (done_c == 0) begin
      chk("frame_done timeout", 0, 1);
    end else begin
      chk("frame_done cycle", 64'(done_c), 64'(f.exp_cycles));
    end
    chk("write count", 64'(wr), 64'(n));
    chk("busy after done", busy, 0);
    chk("done single pulse", frame_done, 0);
    chk("final col", col, 64'(f.w - 13'd1));
    chk("final row", row, 64'(f.h - 13'd1));
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, " pix_ready"}, pix_ready, 0);
    chk({tag, " mem_write"}, mem_write, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " frame_done"}, frame_done, 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " col"}, col, 0);
    chk({tag, " row"}, row, 0);
  endtask

  initial begin
    clear      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    img_width  = '0;
    img_height = '0;
    pix_valid  = 1'b0;
    pix_data   = '0;
    mem_wait   = 1'b0;

    vecs[0] = '{32'h0000_1000, 13'd3, 13'd2, -1, 0, 1'b0, 14};
    vecs[1] = '{32'h0000_1000, 13'd3, 13'd2, 1, 3, 1'b0, 17};
    vecs[2] = '{32'h0000_2000, 13'd1, 13'd1, -1, 0, 1'b0, 4};
    vecs[3] = '{32'hFFFF_FFFC, 13'd2, 13'd1, -1, 0, 1'b0, 6};
    vecs[4] = '{32'h0000_3000, 13'd4, 13'd3, 5, 2, 1'b1, 28};

    repeat (3) @(negedge clk);
    check_idle_reset("reset");
    chk("reset mem_wdata", mem_wdata, 0);
    clear = 1'b0;

    // Zero-dimension starts are ignored.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      base_addr  = 32'h0000_5000;
      img_width  = (i == 0) ? 13'd0 : 13'd4;
      img_height = (i == 0) ? 13'd2 : 13'd0;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("zero dim busy", busy, 0);
      chk("zero dim ready", pix_ready, 0);
      @(negedge clk);
      chk("zero dim busy later", busy, 0);
    end

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i]);
    end

    // Clear while a write is stalled.
    @(negedge clk);
    base_addr  = 32'h0000_1000;
    img_width  = 13'd3;
    img_height = 13'd2;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("clr seq ready", pix_ready, 1);
    pix_valid = 1'b1;
    pix_data  = 24'hABCDEF;
    @(negedge clk);
    pix_valid = 1'b0;
    chk("clr seq write", mem_write, 1);
    chk("clr seq wdata", mem_wdata, 64'h00AB_CDEF);
    mem_wait = 1'b1;
    @(negedge clk);
    chk("clr seq stalled", mem_write, 1);
    clear = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    mem_wait = 1'b0;
    check_idle_reset("after clear");
    @(negedge clk);
    chk("no write after clear", mem_write, 0);
    chk("no done after clear", frame_done, 0);

    run_frame('{32'h0000_4000, 13'd2, 13'd2, -1, 0, 1'b0, 10});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
